// File: rtl/light_pkg.sv
// rtl/light_pkg.sv - shared mode encoding, widths and light decode for the bike light sequencer
//
// Purpose: common definitions used by light_sequencer and its bench.
//   mode_e       : mode encoding OFF=0, ON=1, BLINK=2, FLASH=3
//   MODE_W       : width of the mode output
//   PHASE_W      : width of the pattern phase counter (32 steps)
//   next_mode    : button advance order OFF->ON->BLINK->FLASH->OFF
//   light_decode : LED enable for a given mode, phase and flash pattern
package light_pkg;

  localparam int MODE_W  = 2;
  localparam int PHASE_W = 5;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_FLASH = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_ON;
      MODE_ON:    return MODE_BLINK;
      MODE_BLINK: return MODE_FLASH;
      default:    return MODE_OFF;
    endcase
  endfunction

  // BLINK is on for the first half of the 32-step cycle, which is the
  // phase MSB being clear.
  function automatic logic light_decode(input mode_e m,
                                        input logic [PHASE_W-1:0] p,
                                        input logic [31:0] pat);
    case (m)
      MODE_OFF:   return 1'b0;
      MODE_ON:    return 1'b1;
      MODE_BLINK: return ~p[PHASE_W-1];
      default:    return pat[p];
    endcase
  endfunction

endpackage

// File: rtl/light_sequencer.sv
// rtl/light_sequencer.sv - bike light mode FSM, pattern phase counter and idle auto-off timer
//
// Purpose: steps the light mode on each button press, runs a 32-step
// pattern phase on each beat, and turns the light off after
// TIMEOUT_BEATS beats without a press (0 disables the timeout).
// Ports:
//   clk      : single clock
//   reset    : synchronous, active-high; overrides all inputs
//   beat     : one-cycle pulse, nominally 32 per second
//   btn_next : one-cycle debounced button press
//   light    : registered LED enable
//   mode     : current mode (OFF=0, ON=1, BLINK=2, FLASH=3)
//   phase    : current pattern step 0..31
module light_sequencer
  import light_pkg::*;
#(
  parameter logic [31:0] PATTERN       = 32'h0000_0505,
  parameter int unsigned TIMEOUT_BEATS = 57600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               beat,
  input  logic               btn_next,
  output logic               light,
  output logic [MODE_W-1:0]  mode,
  output logic [PHASE_W-1:0] phase
);

  localparam bit          TIMEOUT_EN   = (TIMEOUT_BEATS != 0);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_BEATS - 1);

  mode_e               mode_q, mode_n;
  logic [PHASE_W-1:0]  phase_q, phase_n;
  logic [15:0]         timer_q, timer_n;
  logic                light_q, light_n;
  logic                timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_OFF;
      phase_q <= '0;
      timer_q <= '0;
      light_q <= 1'b0;
    end else begin
      mode_q  <= mode_n;
      phase_q <= phase_n;
      timer_q <= timer_n;
      light_q <= light_n;
    end
  end

  // The timer only runs outside OFF, so gating on mode keeps a 1-beat
  // timeout from clearing the phase while already off.
  assign timeout_hit = TIMEOUT_EN && beat && (mode_q != MODE_OFF) &&
                       (timer_q == TIMEOUT_LAST);

  always_comb begin
    mode_n  = mode_q;
    phase_n = phase_q;
    timer_n = timer_q;
    // Button has priority over both the timeout and a coincident beat.
    if (btn_next) begin
      mode_n  = next_mode(mode_q);
      phase_n = '0;
      timer_n = '0;
    end else if (timeout_hit) begin
      mode_n  = MODE_OFF;
      phase_n = '0;
      timer_n = '0;
    end else if (beat) begin
      phase_n = phase_q + 5'd1;
      timer_n = (mode_q == MODE_OFF) ? 16'd0 : timer_q + 16'd1;
    end
    // Light is decoded from the next state so it moves on the same edge
    // as mode and phase.
    light_n = light_decode(mode_n, phase_n, PATTERN);
  end

  assign light = light_q;
  assign mode  = mode_q;
  assign phase = phase_q;

endmodule
